receptor_paridade_par: RTL and testbench
========================================

# receptor_paridade_par

Serial even-parity frame receiver: the receive end of the serial even-parity generator link. It takes a bit-serial stream of `DATA_W` data bits (LSB first) followed by one even-parity bit, deserialises the word and checks its parity. It presents the word with a one-cycle valid strobe and an error flag. It keeps a saturating count of parity errors for the status logic above it.

## Interface
Parameters:
- `DATA_W`, default 8: data bits per frame; must be ≥ 1.
- `ERR_W`, default 4: width of the parity-error counter.

Ports:
- `clk`  input  1  clock; all state changes on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  `in_bit` carries a frame bit this cycle.
- `in_bit`  input  1  serial data/parity bit; ignored when `in_valid`=0.
- `abort`  input  1  discard any partial frame and return to IDLE.
- `out_data`  output  `DATA_W`  last completed word; bit 0 = first received bit.
- `out_valid`  output  1  one-cycle strobe: frame completed.
- `parity_err`  output  1  valid only with `out_valid`: received parity mismatched; 0 otherwise.
- `err_count`  output  `ERR_W`  saturating count of frames with `parity_err`=1.
- `busy`  output  1  a frame is in progress (state ≠ IDLE).

## Operation
- States: IDLE, DATA, PARITY. Internal: `bit_cnt` of width clog2(`DATA_W`+1), shift register `sh`, running-XOR register `acc`.
- IDLE, accepted bit (`in_valid`=1, `abort`=0): the bit is data bit 0.
  - `sh[0]` ← bit, `acc` ← bit, `bit_cnt` ← 1.
  - Next state is DATA, or PARITY if `DATA_W`=1.
- DATA, accepted bit: the bit goes to `sh[bit_cnt]`, `acc` ^= bit, `bit_cnt`++. When `bit_cnt` reaches `DATA_W`, next state is PARITY.
- PARITY, accepted bit:
  - `out_data` ← `sh`.
  - `parity_err` ← `acc` ^ bit (even parity: data XOR parity must be 0).
  - `out_valid` ← 1, state ← IDLE, `bit_cnt` ← 0.
- Cycles with `in_valid`=0: no state change, no counter change. Gaps of any length are allowed between bits.
- Error count: when a frame completes with an error, `err_count` increments. At all-ones it holds (saturates, no wrap).
- Abort:
  - `abort`=1 in any state: next state IDLE, `bit_cnt` ← 0, `acc` ← 0. The partial word is dropped and `out_data` is unchanged.
  - `abort` together with `in_valid`: abort wins and the bit is discarded.
  - `abort` during the parity bit: no `out_valid`, no count change.
- `out_data` holds its value until the next completed frame.
- Reset (any state, including mid-frame): IDLE, `bit_cnt`=0, `sh`=0, `acc`=0, `out_data`=0, `out_valid`=0, `parity_err`=0, `err_count`=0, `busy`=0. `reset` has priority over `abort` and `in_valid`.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- A frame occupies at least `DATA_W`+1 accepting edges.
- Latency:
  - If the parity bit is sampled at edge k, then `out_valid`, `parity_err`, `out_data` and the updated `err_count` are visible after edge k.
  - `out_valid` and `parity_err` drop after edge k+1.
- Back-to-back frames are supported: the first data bit of the next frame may be accepted at edge k+1. `busy` is then 1 again after k+1 while `out_valid` clears.
- `busy` goes to 1 after the edge that accepts data bit 0. It goes to 0 after the edge that accepts the parity bit, or after `abort`/`reset`.
- There is no backpressure: the consumer must capture the outputs during the `out_valid` cycle.

## Test plan
- Reset: assert `reset` 2 cycles mid-frame (after 3 bits) → all outputs 0 and `busy`=0. A subsequent full frame decodes correctly.
- Good frame, `DATA_W`=8: bits 1,0,1,0,0,1,0,1 then parity 0, contiguous → after the parity edge, `out_data`=0xA5, `out_valid`=1 for exactly 1 cycle, `parity_err`=0, `err_count`=0.
- Bad frame: 0x01 (1,0,0,0,0,0,0,0) with parity 0 → `parity_err`=1 with `out_valid`, `err_count`=1. Then 0x01 with parity 1 → `parity_err`=0, `err_count` stays 1.
- Gaps and back-to-back:
  - 0x3C with random 0–5 idle cycles between bits → `out_data`=0x3C, `busy` stays high throughout.
  - Immediately followed by 0xFF with parity 0 → two `out_valid` pulses separated by 9 cycles, both with `parity_err`=0.
- Abort: after 4 bits, assert `abort` together with `in_valid` → `busy`=0, no `out_valid`, `out_data` unchanged. Next frame 0x80 with parity 1 → `out_data`=0x80, no error.
- Saturation, `ERR_W`=2, `DATA_W`=1: frames (1,0) sent 5 times → `err_count` goes 1,2,3,3,3, with `parity_err`=1 on each `out_valid`.

Source files
------------

// File: rtl/receptor_paridade_par.sv
// Serial even-parity frame receiver: deserialises DATA_W bits (LSB first) plus one parity bit,
// strobes the word with a parity-error flag and keeps a saturating error count.
module receptor_paridade_par #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ERR_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic              abort,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              parity_err,
    output logic [ERR_W-1:0]  err_count,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              acc_q, acc_d;
    logic [DATA_W-1:0] data_d;
    logic              valid_d;
    logic              perr_d;
    logic [ERR_W-1:0]  count_d;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
        acc_d     = acc_q;
        data_d    = out_data;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        count_d   = err_count;

        // Abort wins over a simultaneous bit; the partial word is simply dropped.
        if (abort) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            acc_d     = 1'b0;
        end else if (in_valid) begin
            case (state_q)
                IDLE: begin
                    sh_d[0]   = in_bit;
                    acc_d     = in_bit;
                    bit_cnt_d = CNT_W'(1);
                    state_d   = (DATA_W == 1) ? PARITY : DATA;
                end
                DATA: begin
                    for (int unsigned i = 0; i < DATA_W; i++) begin
                        if (bit_cnt_q == CNT_W'(i)) sh_d[i] = in_bit;
                    end
                    acc_d     = acc_q ^ in_bit;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_d == CNT_W'(DATA_W)) state_d = PARITY;
                end
                PARITY: begin
                    data_d    = sh_q;
                    perr_d    = acc_q ^ in_bit;
                    valid_d   = 1'b1;
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    if (perr_d && (err_count != '1)) count_d = err_count + 1'b1;
                end
                default: begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            sh_q       <= '0;
            acc_q      <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            parity_err <= 1'b0;
            err_count  <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sh_q       <= sh_d;
            acc_q      <= acc_d;
            out_data   <= data_d;
            out_valid  <= valid_d;
            parity_err <= perr_d;
            err_count  <= count_d;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_receptor_paridade_par.sv
// Self-checking bench for receptor_paridade_par: directed scenarios plus random frames checked
// against a word-level model (word value, parity = XOR reduction, saturating error count).
module tb_receptor_paridade_par;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_bit, abort;
    logic [7:0] out_data;
    logic       out_valid, parity_err, busy;
    logic [3:0] err_count;

    logic       v1, b1, a1;
    logic [0:0] out_data1;
    logic       out_valid1, parity_err1, busy1;
    logic [1:0] err_count1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference state kept at frame level
    int         exp_cnt  = 0;
    logic [7:0] exp_data = 8'h00;

    always #5 clk = ~clk;

    receptor_paridade_par #(.DATA_W(8), .ERR_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .abort(abort),
        .out_data(out_data), .out_valid(out_valid), .parity_err(parity_err),
        .err_count(err_count), .busy(busy)
    );

    receptor_paridade_par #(.DATA_W(1), .ERR_W(2)) dut1 (
        .clk(clk), .reset(reset), .in_valid(v1), .in_bit(b1), .abort(a1),
        .out_data(out_data1), .out_valid(out_valid1), .parity_err(parity_err1),
        .err_count(err_count1), .busy(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Drives one 8-bit frame with random gaps; reports whether busy stayed high and
    // whether a stray out_valid appeared before the parity bit.
    task automatic drive_frame8(input logic [7:0] w, input logic p, input int maxgap,
                                output logic busy_ok, output logic stray_valid);
        int gaps;
        busy_ok     = 1'b1;
        stray_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin
                gaps = $urandom_range(0, maxgap);
                for (int g = 0; g < gaps; g++) begin
                    in_valid = 1'b0;
                    in_bit   = $urandom_range(0, 1);
                    tick();
                    if (!busy) busy_ok = 1'b0;
                    if (out_valid) stray_valid = 1'b1;
                end
            end
            in_valid = 1'b1;
            in_bit   = (i < 8) ? w[i] : p;
            tick();
            in_valid = 1'b0;
            if (i < 8) begin
                if (!busy) busy_ok = 1'b0;
                if (out_valid) stray_valid = 1'b1;
            end
        end
    endtask

    function automatic logic model_err(input logic [7:0] w, input logic p);
        return (^w) ^ p;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic test_reset();
        n_checks++;
        if (out_data !== 8'h00 || out_valid !== 1'b0 || parity_err !== 1'b0 ||
            err_count !== 4'h0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got data=%h v=%b pe=%b cnt=%0d busy=%b, want all 0",
                     out_data, out_valid, parity_err, err_count, busy);
        end
        n_checks++;
        if (out_data1 !== 1'b0 || out_valid1 !== 1'b0 || err_count1 !== 2'd0 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state_dw1: got data=%b v=%b cnt=%0d busy=%b, want all 0",
                     out_data1, out_valid1, err_count1, busy1);
        end
    endtask

    task automatic test_good_frame();
        logic bok, stray;
        drive_frame8(8'hA5, 1'b0, 0, bok, stray);
        exp_data = 8'hA5;
        exp_cnt  = sat(exp_cnt + int'(model_err(8'hA5, 1'b0)), 15);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== exp_data || parity_err !== 1'b0 ||
            err_count !== 4'(exp_cnt)) begin
            n_fail++;
            $display("FAIL good_frame: got v=%b data=%h pe=%b cnt=%0d, want v=1 data=%h pe=0 cnt=%0d",
                     out_valid, out_data, parity_err, err_count, exp_data, exp_cnt);
        end
        n_checks++;
        if (!bok || stray) begin
            n_fail++;
            $display("FAIL good_frame_busy: got busy_ok=%b stray_valid=%b, want 1 0", bok, stray);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || parity_err !== 1'b0 || out_data !== exp_data) begin
            n_fail++;
            $display("FAIL good_frame_pulse: got v=%b pe=%b data=%h, want v=0 pe=0 data=%h",
                     out_valid, parity_err, out_data, exp_data);
        end
    endtask

    task automatic test_reset_mid();
        logic bok, stray;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_bit   = 1'b1;
            tick();
        end
        reset    = 1'b1;
        abort    = 1'b1;
        tick();
        tick();
        reset    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        exp_cnt  = 0;
        exp_data = 8'h00;
        n_checks++;
        if (out_data !== 8'h00 || out_valid !== 1'b0 || parity_err !== 1'b0 ||
            err_count !== 4'h0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got data=%h v=%b pe=%b cnt=%0d busy=%b, want all 0",
                     out_data, out_valid, parity_err, err_count, busy);
        end
        drive_frame8(8'h5A, 1'b0, 0, bok, stray);
        exp_data = 8'h5A;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== exp_data || parity_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_recover: got v=%b data=%h pe=%b, want v=1 data=%h pe=0",
                     out_valid, out_data, parity_err, exp_data);
        end
        tick();
    endtask

    task automatic test_bad_frame();
        logic bok, stray;
        drive_frame8(8'h01, 1'b0, 0, bok, stray);
        exp_data = 8'h01;
        exp_cnt  = sat(exp_cnt + int'(model_err(8'h01, 1'b0)), 15);
        n_checks++;
        if (out_valid !== 1'b1 || parity_err !== 1'b1 || err_count !== 4'(exp_cnt) ||
            out_data !== exp_data) begin
            n_fail++;
            $display("FAIL bad_frame: got v=%b pe=%b cnt=%0d data=%h, want v=1 pe=1 cnt=%0d data=%h",
                     out_valid, parity_err, err_count, out_data, exp_cnt, exp_data);
        end
        drive_frame8(8'h01, 1'b1, 0, bok, stray);
        exp_cnt = sat(exp_cnt + int'(model_err(8'h01, 1'b1)), 15);
        n_checks++;
        if (out_valid !== 1'b1 || parity_err !== 1'b0 || err_count !== 4'(exp_cnt)) begin
            n_fail++;
            $display("FAIL bad_then_good: got v=%b pe=%b cnt=%0d, want v=1 pe=0 cnt=%0d",
                     out_valid, parity_err, err_count, exp_cnt);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic bok, stray;
        int   t1;
        drive_frame8(8'h3C, 1'b0, 5, bok, stray);
        t1 = cyc;
        exp_data = 8'h3C;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== exp_data || parity_err !== 1'b0 || !bok || stray) begin
            n_fail++;
            $display("FAIL gaps_frame: got v=%b data=%h pe=%b busy_ok=%b stray=%b, want 1 %h 0 1 0",
                     out_valid, out_data, parity_err, bok, stray, exp_data);
        end
        drive_frame8(8'hFF, 1'b0, 0, bok, stray);
        exp_data = 8'hFF;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== exp_data || parity_err !== 1'b0 || stray ||
            (cyc - t1) !== 9) begin
            n_fail++;
            $display("FAIL back_to_back: got v=%b data=%h pe=%b stray=%b sep=%0d, want 1 ff 0 0 9",
                     out_valid, out_data, parity_err, stray, cyc - t1);
        end
        tick();
    endtask

    task automatic test_abort();
        logic bok, stray;
        logic seen_valid;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_bit   = 1'b1;
            tick();
        end
        in_valid = 1'b1;
        abort    = 1'b1;
        tick();
        in_valid = 1'b0;
        abort    = 1'b0;
        seen_valid = out_valid;
        n_checks++;
        if (busy !== 1'b0 || seen_valid !== 1'b0 || out_data !== exp_data) begin
            n_fail++;
            $display("FAIL abort: got busy=%b v=%b data=%h, want busy=0 v=0 data=%h",
                     busy, seen_valid, out_data, exp_data);
        end
        // Abort exactly on the parity bit: no strobe, no count change.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_bit   = 1'b0;
            tick();
        end
        in_bit = 1'b1;
        abort  = 1'b1;
        tick();
        in_valid = 1'b0;
        abort    = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || err_count !== 4'(exp_cnt) ||
            out_data !== exp_data) begin
            n_fail++;
            $display("FAIL abort_parity: got v=%b busy=%b cnt=%0d data=%h, want 0 0 %0d %h",
                     out_valid, busy, err_count, out_data, exp_cnt, exp_data);
        end
        drive_frame8(8'h80, 1'b1, 0, bok, stray);
        exp_data = 8'h80;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== exp_data || parity_err !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_recover: got v=%b data=%h pe=%b, want v=1 data=80 pe=0",
                     out_valid, out_data, parity_err);
        end
        tick();
    endtask

    task automatic test_saturation();
        int ref_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            v1 = 1'b1;
            b1 = 1'b1;
            tick();
            b1 = 1'b0;
            tick();
            v1 = 1'b0;
            ref_cnt = sat(ref_cnt + 1, 3);
            n_checks++;
            if (out_valid1 !== 1'b1 || parity_err1 !== 1'b1 || err_count1 !== 2'(ref_cnt) ||
                out_data1 !== 1'b1 || busy1 !== 1'b0) begin
                n_fail++;
                $display("FAIL saturation[%0d]: got v=%b pe=%b cnt=%0d data=%b busy=%b, want 1 1 %0d 1 0",
                         k, out_valid1, parity_err1, err_count1, out_data1, busy1, ref_cnt);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic       bok, stray;
        logic [7:0] w;
        logic       p;
        for (int n = 0; n < 24; n++) begin
            w = 8'($urandom);
            p = 1'($urandom);
            drive_frame8(w, p, 3, bok, stray);
            exp_data = w;
            exp_cnt  = sat(exp_cnt + int'(model_err(w, p)), 15);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp_data || parity_err !== model_err(w, p) ||
                err_count !== 4'(exp_cnt) || !bok || stray) begin
                n_fail++;
                $display("FAIL random[%0d]: got v=%b data=%h pe=%b cnt=%0d, want v=1 data=%h pe=%b cnt=%0d",
                         n, out_valid, out_data, parity_err, err_count, exp_data,
                         model_err(w, p), exp_cnt);
            end
            if ($urandom_range(0, 1) == 1) tick();
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        abort    = 1'b0;
        v1       = 1'b0;
        b1       = 1'b0;
        a1       = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        test_reset();
        test_good_frame();
        test_reset_mid();
        test_bad_frame();
        test_back_to_back();
        test_abort();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
